// File: rtl/resilient_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// resilient_stage_ctrl_if
//   Bundles the left/right 4-phase channels and the error-detection signals of
//   one resilient pipeline stage.
//
//   master : the environment (upstream producer, downstream consumer, detectors)
//   slave  : the stage controller
//
//   lreq/lack/ldata      left 4-phase channel (into the stage)
//   rreq/rack/rdata      right 4-phase channel (out of the stage)
//   err_in               per-group timing-error flags from the detectors
//   sample               detection window active
//   latch_en             one-cycle capture strobe
//   err_map              OR of err_in over the last detection window
//   err_cnt              saturating count of tokens that saw an error
//   err_clr              synchronous clear of err_cnt
// -----------------------------------------------------------------------------
interface resilient_stage_ctrl_if #(
    parameter int DW    = 32,
    parameter int NGRP  = 4,
    parameter int CNT_W = 16
);
    logic             lreq;
    logic             lack;
    logic [DW-1:0]    ldata;
    logic             rreq;
    logic             rack;
    logic [DW-1:0]    rdata;
    logic [NGRP-1:0]  err_in;
    logic             sample;
    logic             latch_en;
    logic [NGRP-1:0]  err_map;
    logic [CNT_W-1:0] err_cnt;
    logic             err_clr;

    modport master (
        output lreq, ldata, rack, err_in, err_clr,
        input  lack, rreq, rdata, sample, latch_en, err_map, err_cnt
    );

    modport slave (
        input  lreq, ldata, rack, err_in, err_clr,
        output lack, rreq, rdata, sample, latch_en, err_map, err_cnt
    );
endinterface

// File: rtl/resilient_stage_ctrl.sv
// -----------------------------------------------------------------------------
// resilient_stage_ctrl
//   Clocked controller for one resilient pipeline stage. A token arriving on
//   the left 4-phase channel is captured, watched by the error detectors for a
//   DET_CYC-cycle window, re-captured after a REC_CYC-cycle recovery wait if
//   any detector fired, and then offered on the right 4-phase channel. Tokens
//   that saw an error are counted and the detector groups that fired are kept
//   in err_map.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   bus        resilient_stage_ctrl_if.slave (channels, detector signals)
//   dbg_state  current FSM state (IDLE=0, CAPT=1, DET=2, REC=3, SEND=4)
//
// Handshake (both channels are 4-phase, request/acknowledge):
//   Left : lreq rises with ldata valid; lack rises when the token is sent on
//          the right side; lreq falls; lack falls the cycle after lreq=0 is
//          seen. A new capture needs lreq=1 with lack=0 and rack=0.
//   Right: rreq rises with rdata valid and stays high until rack=1 is seen;
//          rreq falls the next cycle; rack must fall before the next capture.
//   The left return-to-zero may overlap the right handshake.
// -----------------------------------------------------------------------------
module resilient_stage_ctrl #(
    parameter int DW      = 32,
    parameter int NGRP    = 4,
    parameter int DET_CYC = 2,    // legal 1..15
    parameter int REC_CYC = 4,    // legal 1..15
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    resilient_stage_ctrl_if.slave  bus,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CAPT = 3'd1,
        DET  = 3'd2,
        REC  = 3'd3,
        SEND = 3'd4
    } state_t;

    // Counters load "cycles - 1" and the state exits when they reach zero.
    localparam logic [3:0] DET_LAST = 4'(DET_CYC - 1);
    localparam logic [3:0] REC_LAST = 4'(REC_CYC - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       det_err_exit;

    // The exit decision includes this cycle's flags, which are only being
    // folded into err_map on the same edge.
    assign det_err_exit = (state == DET) && (cnt == 4'd0) &&
                          ((bus.err_map | bus.err_in) != '0);

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            bus.lack     <= 1'b0;
            bus.rreq     <= 1'b0;
            bus.sample   <= 1'b0;
            bus.latch_en <= 1'b0;
            bus.rdata    <= '0;
            bus.err_map  <= '0;
            bus.err_cnt  <= '0;
        end else begin
            // The strobe is a one-cycle pulse unless a transition re-arms it.
            bus.latch_en <= 1'b0;

            // Data moves only on the edge that closes a latch_en cycle.
            if (bus.latch_en) begin
                bus.rdata <= bus.ldata;
            end

            // Left return-to-zero is independent of the FSM state.
            if (bus.lack && !bus.lreq) begin
                bus.lack <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.lreq && !bus.lack && !bus.rack) begin
                        state        <= CAPT;
                        bus.latch_en <= 1'b1;
                    end
                end

                CAPT: begin
                    state      <= DET;
                    cnt        <= DET_LAST;
                    bus.sample <= 1'b1;
                    bus.err_map <= '0;
                end

                DET: begin
                    bus.err_map <= bus.err_map | bus.err_in;
                    if (cnt == 4'd0) begin
                        bus.sample <= 1'b0;
                        if (det_err_exit) begin
                            state        <= REC;
                            cnt          <= REC_LAST;
                            // With a one-cycle recovery the first REC cycle
                            // is also the re-capture cycle.
                            bus.latch_en <= (REC_LAST == 4'd0);
                        end else begin
                            state    <= SEND;
                            bus.rreq <= 1'b1;
                            bus.lack <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                REC: begin
                    // err_in is ignored here; a second error on the same
                    // token is not looked for.
                    if (cnt == 4'd0) begin
                        state    <= SEND;
                        bus.rreq <= 1'b1;
                        bus.lack <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            bus.latch_en <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (bus.rack) begin
                        state    <= IDLE;
                        bus.rreq <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // Clear wins over a simultaneous error; the counter never wraps.
            if (bus.err_clr) begin
                bus.err_cnt <= '0;
            end else if (det_err_exit && (bus.err_cnt != '1)) begin
                bus.err_cnt <= bus.err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_resilient_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_resilient_stage_ctrl
//   Self-checking bench for resilient_stage_ctrl. Each token is described by
//   its timeline relative to the cycle in which lreq is raised (cycle 0); the
//   reference model derives from the stage's rules which cycles must show
//   latch_en, sample, rreq and lack, what rdata must carry, which detector
//   groups must appear in err_map and how err_cnt evolves.
// -----------------------------------------------------------------------------
module tb_resilient_stage_ctrl;

    localparam int DW      = 32;
    localparam int NGRP    = 4;
    localparam int DET_CYC = 2;
    localparam int REC_CYC = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    resilient_stage_ctrl_if #(.DW(DW), .NGRP(NGRP), .CNT_W(CNT_W)) bus ();

    resilient_stage_ctrl #(
        .DW(DW), .NGRP(NGRP), .DET_CYC(DET_CYC), .REC_CYC(REC_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;
    int model_cnt   = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.lreq    = 1'b0;
        bus.ldata   = '0;
        bus.rack    = 1'b0;
        bus.err_in  = '0;
        bus.err_clr = 1'b0;
    endtask

    // One token. hold: cycles rack is (illegally) held high at the start.
    // want_err: token sees detector flags; wmask/wcyc: directed flag pattern
    // (wmask=0 -> random pattern). rack_dly/lreq_dly: environment reaction
    // delays after rreq/lack rise. clr_at_exit: pulse err_clr on the exit
    // edge of the detection window.
    task automatic run_token(input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                             input int hold, input bit want_err,
                             input logic [NGRP-1:0] wmask, input int wcyc,
                             input int rack_dly, input int lreq_dly,
                             input bit clr_at_exit);
        logic [NGRP-1:0] win [DET_CYC];
        logic [NGRP-1:0] exp_map;
        logic [DW-1:0]   exp_data;
        bit              err;
        int base, l, k_rack, k_lfall, k_end;

        exp_map = '0;
        for (int j = 0; j < DET_CYC; j++) begin
            if (!want_err)       win[j] = '0;
            else if (wmask != 0) win[j] = (j == wcyc) ? wmask : '0;
            else                 win[j] = NGRP'($urandom_range(0, 15));
            exp_map |= win[j];
        end
        if (want_err && exp_map == '0) begin
            win[DET_CYC-1] = 4'b0100;
            exp_map        = 4'b0100;
        end
        err      = (exp_map != '0);
        exp_data = err ? d2 : d1;
        exp_q.push_back(exp_data);

        base    = hold;
        l       = base + 2 + DET_CYC + (err ? REC_CYC : 0);
        k_rack  = l + rack_dly;
        k_lfall = l + lreq_dly;
        k_end   = (k_lfall + 1 > k_rack + 2) ? k_lfall + 1 : k_rack + 2;

        for (int k = 0; k <= k_end; k++) begin
            @(posedge clk);
            #1;
            bus.lreq    = (k < k_lfall);
            bus.ldata   = (k >= k_lfall) ? DW'($urandom) :
                          (err && k >= base + 2) ? d2 : d1;
            bus.err_in  = (k >= base + 2 && k <= base + 1 + DET_CYC) ?
                          win[k - base - 2] : NGRP'($urandom_range(0, 15));
            bus.rack    = (k < hold) || (k >= k_rack && k < k_rack + 2);
            bus.err_clr = clr_at_exit && (k == base + 1 + DET_CYC);

            // Counter model: the window's exit edge closes this cycle.
            if (k == base + 1 + DET_CYC) begin
                if (clr_at_exit)                 model_cnt = 0;
                else if (err && model_cnt < CNT_MAX) model_cnt++;
            end

            @(negedge clk);
            check("latch_en", 32'(bus.latch_en),
                  32'((k == base + 1) || (err && k == base + 1 + DET_CYC + REC_CYC)));
            check("sample", 32'(bus.sample), 32'(k >= base + 2 && k <= base + 1 + DET_CYC));
            check("rreq", 32'(bus.rreq), 32'(k >= l && k <= k_rack));
            check("lack", 32'(bus.lack), 32'(k >= l && k <= k_lfall));
            if (k == l) begin
                check("rdata", 32'(bus.rdata), 32'(exp_q.pop_front()));
                check("err_map", 32'(bus.err_map), 32'(exp_map));
                check("err_cnt", 32'(bus.err_cnt), 32'(model_cnt));
            end else if (k > l && k <= k_rack) begin
                check("rdata_hold", 32'(bus.rdata), 32'(exp_data));
            end
        end
    endtask

    // Token abandoned by a reset pulse in the first detection cycle.
    task automatic reset_mid_token();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            bus.lreq   = (k < 2);
            bus.ldata  = DW'($urandom);
            bus.err_in = NGRP'($urandom_range(0, 15));
            rst        = (k == 2);
            @(negedge clk);
            if (k == 2) check("pre_rst_sample", 32'(bus.sample), 32'd1);
        end
        model_cnt = 0;
        check("rst_lack", 32'(bus.lack), 32'd0);
        check("rst_rreq", 32'(bus.rreq), 32'd0);
        check("rst_sample", 32'(bus.sample), 32'd0);
        check("rst_latch_en", 32'(bus.latch_en), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_err_map", 32'(bus.err_map), 32'd0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("init_lack", 32'(bus.lack), 32'd0);
        check("init_rreq", 32'(bus.rreq), 32'd0);
        check("init_sample", 32'(bus.sample), 32'd0);
        check("init_latch_en", 32'(bus.latch_en), 32'd0);
        check("init_rdata", 32'(bus.rdata), 32'd0);
        check("init_err_map", 32'(bus.err_map), 32'd0);
        check("init_err_cnt", 32'(bus.err_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Clean token, then the same token with a late-window error and data
        // changed before the re-capture.
        run_token(32'hA5A5_0001, 32'h0, 0, 1'b0, '0, 0, 3, 1, 1'b0);
        run_token(32'hA5A5_0001, 32'h0000_BEEF, 0, 1'b1, 4'b0100, 1, 3, 1, 1'b0);

        // Ten back-to-back clean tokens, rack three cycles after rreq.
        for (int i = 0; i < 10; i++)
            run_token(DW'($urandom), DW'($urandom), 0, 1'b0, '0, 0, 3, 1, 1'b0);

        // Clear, then saturate the counter, then clear against an error.
        run_token(DW'($urandom), DW'($urandom), 0, 1'b1, '0, 0, 2, 2, 1'b1);
        for (int i = 0; i < 5; i++)
            run_token(DW'($urandom), DW'($urandom), 0, 1'b1, '0, 0, 1, 1, 1'b0);
        run_token(DW'($urandom), DW'($urandom), 0, 1'b1, '0, 0, 1, 1, 1'b1);

        // rack held high in IDLE blocks capture.
        run_token(DW'($urandom), DW'($urandom), 3, 1'b0, '0, 0, 2, 1, 1'b0);

        // Reset during detection, then a fresh token.
        reset_mid_token();
        run_token(32'h1234_5678, DW'($urandom), 0, 1'b0, '0, 0, 1, 1, 1'b0);

        // Randomized tokens.
        for (int i = 0; i < 40; i++)
            run_token(DW'($urandom), DW'($urandom), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), '0, 0,
                      $urandom_range(1, 4), $urandom_range(1, 3),
                      ($urandom_range(0, 7) == 0));

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
